// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter_if : request/response/memory bundle for the two-port arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
    // op: 0=read 1=write; access_size: 0=byte 1=half 2=word
    typedef struct packed {
        logic       op;
        logic [1:0] access_size;
        logic       read_unsigned;
    } mem_params_t;

    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_addr;
    logic        if_resp_valid;
    logic        if_resp_ready;
    logic [31:0] if_resp_data;
    logic        if_resp_err;

    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    mem_params_t ls_params;
    logic        ls_resp_valid;
    logic        ls_resp_ready;
    logic [31:0] ls_resp_data;
    logic        ls_resp_err;

    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    mem_params_t mem_params;
    logic [31:0] mem_data_out;

    modport slave (
        input  if_req_valid, if_addr, if_resp_ready,
        input  ls_req_valid, ls_addr, ls_wdata, ls_params, ls_resp_ready,
        input  mem_data_out,
        output if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
        output ls_req_ready, ls_resp_valid, ls_resp_data, ls_resp_err,
        output mem_address, mem_data_in, mem_params
    );

    modport master (
        output if_req_valid, if_addr, if_resp_ready,
        output ls_req_valid, ls_addr, ls_wdata, ls_params, ls_resp_ready,
        output mem_data_out,
        input  if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
        input  ls_req_ready, ls_resp_valid, ls_resp_data, ls_resp_err,
        input  mem_address, mem_data_in, mem_params
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : fetch/LSU arbiter in front of a unified byte-addressed memory
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int         SW         = $clog2(MAX_LSU_STREAK + 1);
    localparam logic       OP_WRITE   = 1'b1;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [3:0] READ_WORD  = {1'b0, SIZE_WORD, 1'b1};
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);

    typedef enum logic [0:0] {IDLE = 1'b0, RESP = 1'b1} state_t;

    state_t        state;
    logic          owner_ls;
    logic [SW-1:0] streak;

    logic        if_valid_q, ls_valid_q, if_err_q, ls_err_q;
    logic [31:0] if_data_q, ls_data_q;

    logic        owner_ready, window, grant_ls, grant_if;
    logic        ls_misaligned, if_misaligned, misaligned, issue, is_write;
    logic [31:0] addr_mux, wdata_mux, resp_data;
    logic [3:0]  params_mux;

    always_comb begin
        owner_ready = owner_ls ? bus.ls_resp_ready : bus.if_resp_ready;
        window      = !reset && (state == IDLE || owner_ready);
        // LSU wins ties until it has starved a waiting fetch MAX_LSU_STREAK times
        grant_ls    = window && bus.ls_req_valid &&
                      !(bus.if_req_valid && streak == STREAK_MAX);
        grant_if    = window && bus.if_req_valid && !grant_ls;

        ls_misaligned = (bus.ls_params.access_size == SIZE_HALF && bus.ls_addr[0]) ||
                        (bus.ls_params.access_size == SIZE_WORD && bus.ls_addr[1:0] != 2'b00);
        if_misaligned = bus.if_addr[1:0] != 2'b00;
        misaligned    = grant_ls ? ls_misaligned : (grant_if && if_misaligned);
        issue         = (grant_ls || grant_if) && !misaligned;
        is_write      = grant_ls && bus.ls_params.op == OP_WRITE;

        addr_mux   = 32'd0;
        wdata_mux  = 32'd0;
        params_mux = READ_WORD;
        if (issue) begin
            if (grant_ls) begin
                addr_mux   = bus.ls_addr;
                wdata_mux  = bus.ls_wdata;
                params_mux = bus.ls_params;
            end else begin
                addr_mux   = bus.if_addr;
            end
        end

        resp_data = (misaligned || is_write) ? 32'd0 : bus.mem_data_out;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner_ls   <= 1'b0;
            streak     <= '0;
            if_valid_q <= 1'b0;
            if_data_q  <= 32'd0;
            if_err_q   <= 1'b0;
            ls_valid_q <= 1'b0;
            ls_data_q  <= 32'd0;
            ls_err_q   <= 1'b0;
        end else begin
            if (grant_ls) begin
                state      <= RESP;
                owner_ls   <= 1'b1;
                ls_valid_q <= 1'b1;
                ls_data_q  <= resp_data;
                ls_err_q   <= misaligned;
                if_valid_q <= 1'b0;
                if_data_q  <= 32'd0;
                if_err_q   <= 1'b0;
            end else if (grant_if) begin
                state      <= RESP;
                owner_ls   <= 1'b0;
                if_valid_q <= 1'b1;
                if_data_q  <= resp_data;
                if_err_q   <= misaligned;
                ls_valid_q <= 1'b0;
                ls_data_q  <= 32'd0;
                ls_err_q   <= 1'b0;
            end else if (state == RESP && owner_ready) begin
                state      <= IDLE;
                if_valid_q <= 1'b0;
                if_data_q  <= 32'd0;
                if_err_q   <= 1'b0;
                ls_valid_q <= 1'b0;
                ls_data_q  <= 32'd0;
                ls_err_q   <= 1'b0;
            end

            if (grant_if || !bus.if_req_valid)
                streak <= '0;
            else if (grant_ls && streak != STREAK_MAX)
                streak <= streak + SW'(1);
        end
    end

    assign bus.if_req_ready  = grant_if;
    assign bus.ls_req_ready  = grant_ls;
    assign bus.if_resp_valid = if_valid_q;
    assign bus.if_resp_data  = if_data_q;
    assign bus.if_resp_err   = if_err_q;
    assign bus.ls_resp_valid = ls_valid_q;
    assign bus.ls_resp_data  = ls_data_q;
    assign bus.ls_resp_err   = ls_err_q;
    assign bus.mem_address   = addr_mux;
    assign bus.mem_data_in   = wdata_mux;
    assign bus.mem_params    = params_mux;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed vector bench for mem_arbiter with a byte memory
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_LSU_STREAK(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // byte memory: combinational, extending read; write at posedge
    logic [7:0]  mem_bytes [0:1023];
    logic [9:0]  ma;
    logic [31:0] raw;

    always_comb begin
        ma  = bus.mem_address[9:0];
        raw = {mem_bytes[10'(ma + 10'd3)], mem_bytes[10'(ma + 10'd2)],
               mem_bytes[10'(ma + 10'd1)], mem_bytes[ma]};
        case (bus.mem_params.access_size)
            2'd0:    bus.mem_data_out = bus.mem_params.read_unsigned ?
                                        {24'd0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
            2'd1:    bus.mem_data_out = bus.mem_params.read_unsigned ?
                                        {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: bus.mem_data_out = raw;
        endcase
    end

    always @(posedge clock) begin
        if (bus.mem_params.op) begin
            mem_bytes[ma] <= bus.mem_data_in[7:0];
            if (bus.mem_params.access_size != 2'd0)
                mem_bytes[10'(ma + 10'd1)] <= bus.mem_data_in[15:8];
            if (bus.mem_params.access_size == 2'd2) begin
                mem_bytes[10'(ma + 10'd2)] <= bus.mem_data_in[23:16];
                mem_bytes[10'(ma + 10'd3)] <= bus.mem_data_in[31:24];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // params encoding {op, size, unsigned}
    localparam logic [3:0] P_SB = 4'b1_00_0, P_LB = 4'b0_00_0, P_LBU = 4'b0_00_1;
    localparam logic [3:0] P_LH = 4'b0_01_0, P_SH = 4'b1_01_0;
    localparam logic [3:0] P_LW = 4'b0_10_0, P_SW = 4'b1_10_0;

    typedef struct {
        logic        if_v;
        logic [31:0] if_a;
        logic        ls_v;
        logic [31:0] ls_a;
        logic [31:0] wd;
        logic [3:0]  prm;
        logic        e_ifr;
        logic        e_lsr;
        logic        e_wr;
        logic        e_ifv;
        logic [31:0] e_ifd;
        logic        e_ife;
        logic        e_lsv;
        logic [31:0] e_lsd;
        logic        e_lse;
    } vec_t;

    vec_t vecs [13];

    task automatic drive(input logic iv, input logic [31:0] ia, input logic lv,
                         input logic [31:0] la, input logic [31:0] wd, input logic [3:0] prm);
        bus.if_req_valid = iv;
        bus.if_addr      = ia;
        bus.ls_req_valid = lv;
        bus.ls_addr      = la;
        bus.ls_wdata     = wd;
        bus.ls_params    = prm;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_bytes[i] <= 8'h00;
        {mem_bytes[10'h103], mem_bytes[10'h102], mem_bytes[10'h101], mem_bytes[10'h100]} <= 32'hDEADBEEF;
        {mem_bytes[10'h303], mem_bytes[10'h302], mem_bytes[10'h301], mem_bytes[10'h300]} <= 32'h11223344;
        {mem_bytes[10'h403], mem_bytes[10'h402], mem_bytes[10'h401], mem_bytes[10'h400]} <= 32'h12345678;

        //            ifv ifa     lsv lsa     wdata        prm    ifr lsr wr ifv ifd           ife lsv lsd           lse
        vecs[0]  = '{1, 32'h100, 0, 32'h0,   32'h0,       P_LW,  1,  0,  0, 1, 32'hDEADBEEF, 0,  0, 32'h0,        0};
        vecs[1]  = '{0, 32'h0,   1, 32'h201, 32'h80,      P_SB,  0,  1,  1, 0, 32'h0,        0,  1, 32'h0,        0};
        vecs[2]  = '{0, 32'h0,   1, 32'h201, 32'h0,       P_LB,  0,  1,  0, 0, 32'h0,        0,  1, 32'hFFFFFF80, 0};
        vecs[3]  = '{0, 32'h0,   1, 32'h201, 32'h0,       P_LBU, 0,  1,  0, 0, 32'h0,        0,  1, 32'h00000080, 0};
        vecs[4]  = '{0, 32'h0,   1, 32'h200, 32'h0,       P_LH,  0,  1,  0, 0, 32'h0,        0,  1, 32'hFFFF8000, 0};
        vecs[5]  = '{0, 32'h0,   1, 32'h302, 32'hFFFFFFFF, P_SW, 0,  1,  0, 0, 32'h0,        0,  1, 32'h0,        1};
        vecs[6]  = '{0, 32'h0,   1, 32'h300, 32'h0,       P_LW,  0,  1,  0, 0, 32'h0,        0,  1, 32'h11223344, 0};
        vecs[7]  = '{1, 32'h101, 0, 32'h0,   32'h0,       P_LW,  1,  0,  0, 1, 32'h0,        1,  0, 32'h0,        0};
        vecs[8]  = '{0, 32'h0,   1, 32'h203, 32'h0,       P_LH,  0,  1,  0, 0, 32'h0,        0,  1, 32'h0,        1};
        vecs[9]  = '{0, 32'h0,   1, 32'h202, 32'hBEEF,    P_SH,  0,  1,  1, 0, 32'h0,        0,  1, 32'h0,        0};
        vecs[10] = '{0, 32'h0,   1, 32'h200, 32'h0,       P_LW,  0,  1,  0, 0, 32'h0,        0,  1, 32'hBEEF8000, 0};
        vecs[11] = '{0, 32'h0,   0, 32'h0,   32'h0,       P_LW,  0,  0,  0, 0, 32'h0,        0,  0, 32'h0,        0};
        vecs[12] = '{1, 32'h100, 1, 32'h300, 32'h0,       P_LW,  0,  1,  0, 0, 32'h0,        0,  1, 32'h11223344, 0};

        drive(0, 0, 0, 0, 0, P_LW);
        bus.if_resp_ready = 1'b1;
        bus.ls_resp_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_if_req_ready", 32'(bus.if_req_ready), 0);
        chk("rst_ls_req_ready", 32'(bus.ls_req_ready), 0);
        chk("rst_if_resp_valid", 32'(bus.if_resp_valid), 0);
        chk("rst_ls_resp_valid", 32'(bus.ls_resp_valid), 0);
        chk("rst_if_resp_data", bus.if_resp_data, 0);
        chk("rst_ls_resp_data", bus.ls_resp_data, 0);
        chk("rst_ls_resp_err", 32'(bus.ls_resp_err), 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            @(negedge clock);
            drive(vecs[i].if_v, vecs[i].if_a, vecs[i].ls_v, vecs[i].ls_a, vecs[i].wd, vecs[i].prm);
            #1;
            chk($sformatf("v%0d_if_req_ready", i), 32'(bus.if_req_ready), 32'(vecs[i].e_ifr));
            chk($sformatf("v%0d_ls_req_ready", i), 32'(bus.ls_req_ready), 32'(vecs[i].e_lsr));
            chk($sformatf("v%0d_mem_op", i), 32'(bus.mem_params.op), 32'(vecs[i].e_wr));
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_if_resp_valid", i), 32'(bus.if_resp_valid), 32'(vecs[i].e_ifv));
            chk($sformatf("v%0d_ls_resp_valid", i), 32'(bus.ls_resp_valid), 32'(vecs[i].e_lsv));
            if (vecs[i].e_ifv) begin
                chk($sformatf("v%0d_if_resp_data", i), bus.if_resp_data, vecs[i].e_ifd);
                chk($sformatf("v%0d_if_resp_err", i), 32'(bus.if_resp_err), 32'(vecs[i].e_ife));
            end
            if (vecs[i].e_lsv) begin
                chk($sformatf("v%0d_ls_resp_data", i), bus.ls_resp_data, vecs[i].e_lsd);
                chk($sformatf("v%0d_ls_resp_err", i), 32'(bus.ls_resp_err), 32'(vecs[i].e_lse));
            end
        end

        // fairness: both requesting every cycle, fetch forced through every 5th grant
        @(negedge clock);
        drive(0, 0, 0, 0, 0, P_LW);
        @(posedge clock);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            drive(1, 32'h100, 1, 32'h300, 0, P_LW);
            #1;
            chk($sformatf("fair%0d_ls_req_ready", k), 32'(bus.ls_req_ready), 32'((k % 5) != 4));
            chk($sformatf("fair%0d_if_req_ready", k), 32'(bus.if_req_ready), 32'((k % 5) == 4));
            @(posedge clock);
            #1;
            if ((k % 5) != 4) begin
                chk($sformatf("fair%0d_ls_resp", k), bus.ls_resp_data, 32'h11223344);
                chk($sformatf("fair%0d_if_quiet", k), 32'(bus.if_resp_valid), 0);
            end else begin
                chk($sformatf("fair%0d_if_resp", k), bus.if_resp_data, 32'hDEADBEEF);
                chk($sformatf("fair%0d_ls_quiet", k), 32'(bus.ls_resp_valid), 0);
            end
        end

        // backpressure on the LSU response
        @(negedge clock);
        drive(0, 0, 0, 0, 0, P_LW);
        @(posedge clock);
        @(negedge clock);
        bus.ls_resp_ready = 1'b0;
        drive(0, 0, 1, 32'h400, 0, P_LW);
        #1;
        chk("bp_first_accept", 32'(bus.ls_req_ready), 1);
        @(posedge clock);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            drive(1, 32'h100, 1, 32'h300, 0, P_LW);
            #1;
            chk($sformatf("bp%0d_ls_valid", k), 32'(bus.ls_resp_valid), 1);
            chk($sformatf("bp%0d_ls_data", k), bus.ls_resp_data, 32'h12345678);
            chk($sformatf("bp%0d_ls_req_ready", k), 32'(bus.ls_req_ready), 0);
            chk($sformatf("bp%0d_if_req_ready", k), 32'(bus.if_req_ready), 0);
            @(posedge clock);
        end
        @(negedge clock);
        bus.ls_resp_ready = 1'b1;
        #1;
        chk("bp_release_accept", 32'(bus.ls_req_ready), 1);
        @(posedge clock);
        #1;
        chk("bp_next_data", bus.ls_resp_data, 32'h11223344);

        // reset while a response is held, with a store pending
        @(negedge clock);
        drive(0, 0, 1, 32'h400, 0, P_LW);
        bus.ls_resp_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        drive(1, 32'h100, 1, 32'h300, 32'hCAFEF00D, P_SW);
        #1;
        chk("rr_ls_req_ready", 32'(bus.ls_req_ready), 0);
        chk("rr_if_req_ready", 32'(bus.if_req_ready), 0);
        chk("rr_mem_op", 32'(bus.mem_params.op), 0);
        @(posedge clock);
        #1;
        chk("rr_ls_resp_valid", 32'(bus.ls_resp_valid), 0);
        chk("rr_if_resp_valid", 32'(bus.if_resp_valid), 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, P_LW);
        bus.ls_resp_ready = 1'b1;
        chk("rr_mem_unchanged",
            {mem_bytes[10'h303], mem_bytes[10'h302], mem_bytes[10'h301], mem_bytes[10'h300]},
            32'h11223344);
        @(posedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
